// File: rtl/serial_magnitude_compare.sv
// rtl/serial_magnitude_compare.sv - digit-serial MSB-first magnitude comparator with start/busy/done handshake
module serial_magnitude_compare #(
    parameter int WIDTH      = 6,
    parameter int DIGIT      = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    // Operands are held MSB-aligned and shifted left, so the digit under test
    // is always the top DIGIT bits; idx_q only counts the remaining digits.
    logic [DIGIT-1:0] dig_a, dig_b;
    logic             decided;
    logic [WIDTH-1:0] a_lat;

    // Next-state, operand shift and result recording
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        dig_a   = a_q[WIDTH-1 -: DIGIT];
        dig_b   = b_q[WIDTH-1 -: DIGIT];
        decided = gt_q | lt_q;
        // Flipping both sign bits maps two's-complement order onto unsigned order
        a_lat              = a;
        a_lat[WIDTH-1]     = a[WIDTH-1] ^ signed_mode;

        case (state_q)
            S_RUN: begin
                if (!decided && (dig_a != dig_b)) begin
                    gt_d = (dig_a > dig_b);
                    lt_d = ~(dig_a > dig_b);
                    if (EARLY_EXIT != 0) begin
                        state_d = S_DONE;
                    end
                end
                if (idx_q == '0) begin
                    state_d = S_DONE;
                    if (!decided && (dig_a == dig_b)) begin
                        eq_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
                a_d = a_q << DIGIT;
                b_d = b_q << DIGIT;
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise lasts one cycle
                if (start) begin
                    a_d     = a_lat;
                    b_d     = b;
                    b_d[WIDTH-1] = b[WIDTH-1] ^ signed_mode;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    idx_d   = IW'(N - 1);
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State registers; reset aborts any compare in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule
